// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// -----------------
// Registered operand-select stage placed between decode/register-read and the
// ALU. Operand A and operand B are each selected from NUM_IN candidate sources
// (register file, immediate, EX/MEM forwards, ...). The selected pair is held
// in a two-entry buffer behind a valid/ready handshake. o_in_ready comes from a
// register, so ALU back-pressure never creates a combinational path upstream.
//
// Optional feature (macro ALU_OPERAND_SEL_CHECK_EN):
//   defined   - a select >= NUM_IN zeroes that operand, and o_sel_err is stored
//               with the entry and presented while the entry is at the output.
//   undefined - an out-of-range select picks source 0, and o_sel_err is tied
//               to 0.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      synchronous, active-high reset
//   i_in_data    flattened sources; source k is at [k*WIDTH +: WIDTH]
//   i_sel_a      source index for operand A
//   i_sel_b      source index for operand B
//   i_in_valid   upstream presents a request
//   o_in_ready   stage can accept a request this cycle
//   o_op_a       registered operand A
//   o_op_b       registered operand B
//   o_out_valid  o_op_a/o_op_b hold valid data
//   i_out_ready  ALU accepts the pair this cycle
//   o_sel_err    out-of-range select flag for the entry at the output
//   o_occupancy  number of entries held (0, 1 or 2)

module alu_operand_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_IN*WIDTH-1:0] i_in_data,
    input  logic [SEL_W-1:0]        i_sel_a,
    input  logic [SEL_W-1:0]        i_sel_b,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    output logic [WIDTH-1:0]        o_op_a,
    output logic [WIDTH-1:0]        o_op_b,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic                    o_sel_err,
    output logic [1:0]              o_occupancy
);

    localparam int unsigned NUM_SLOTS = 2 ** SEL_W;

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_main_a;
    logic [WIDTH-1:0]   r_main_b;
    logic [WIDTH-1:0]   r_skid_a;
    logic [WIDTH-1:0]   r_skid_b;

    logic [WIDTH-1:0]   w_table [NUM_SLOTS];
    logic [WIDTH-1:0]   w_new_a;
    logic [WIDTH-1:0]   w_new_b;
    logic               w_accept;
    logic               w_drain;

    // Every select code maps to a fixed table slot, so out-of-range handling
    // is decided at elaboration time: pad slots hold zero or source 0.
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_table
        if (k < NUM_IN) begin : g_src
            assign w_table[k] = i_in_data[k*WIDTH +: WIDTH];
        end else begin : g_pad
`ifdef ALU_OPERAND_SEL_CHECK_EN
            assign w_table[k] = '0;
`else
            assign w_table[k] = i_in_data[0 +: WIDTH];
`endif
        end
    end

    assign w_new_a  = w_table[i_sel_a];
    assign w_new_b  = w_table[i_sel_b];
    assign w_accept = i_in_valid & r_in_ready;
    assign w_drain  = r_out_valid & i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StEmpty;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_a    <= '0;
            r_main_b    <= '0;
            r_skid_a    <= '0;
            r_skid_b    <= '0;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        r_main_a    <= w_new_a;
                        r_main_b    <= w_new_b;
                        r_out_valid <= 1'b1;
                        r_state     <= StOne;
                    end
                end
                StOne: begin
                    if (w_accept && w_drain) begin
                        // Full-throughput case: main reloads in place.
                        r_main_a <= w_new_a;
                        r_main_b <= w_new_b;
                    end else if (w_accept) begin
                        r_skid_a   <= w_new_a;
                        r_skid_b   <= w_new_b;
                        r_in_ready <= 1'b0;
                        r_state    <= StTwo;
                    end else if (w_drain) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StEmpty;
                    end
                end
                StTwo: begin
                    if (w_drain) begin
                        r_main_a   <= r_skid_a;
                        r_main_b   <= r_skid_b;
                        r_in_ready <= 1'b1;
                        r_state    <= StOne;
                    end
                end
                default: begin
                    r_state     <= StEmpty;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_OPERAND_SEL_CHECK_EN
    logic r_main_err;
    logic r_skid_err;
    logic w_err_new;

    assign w_err_new = (32'(i_sel_a) >= NUM_IN) | (32'(i_sel_b) >= NUM_IN);

    // Error flags follow their entries through the same moves as the data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_main_err <= 1'b0;
            r_skid_err <= 1'b0;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_accept) r_main_err <= w_err_new;
                end
                StOne: begin
                    if (w_accept && w_drain) r_main_err <= w_err_new;
                    else if (w_accept)       r_skid_err <= w_err_new;
                    else if (w_drain)        r_main_err <= 1'b0;
                end
                StTwo: begin
                    if (w_drain) begin
                        r_main_err <= r_skid_err;
                        r_skid_err <= 1'b0;
                    end
                end
                default: begin
                    r_main_err <= 1'b0;
                    r_skid_err <= 1'b0;
                end
            endcase
        end
    end

    assign o_sel_err = r_main_err;
`else
    assign o_sel_err = 1'b0;
`endif

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_op_a      = r_main_a;
    assign o_op_b      = r_main_b;
    assign o_occupancy = r_state;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [N*W-1:0]   in_data;
    logic [SW-1:0]    sel_a, sel_b;
    logic             in_valid, in_ready;
    logic [W-1:0]     op_a, op_b;
    logic             out_valid, out_ready, sel_err;
    logic [1:0]       occupancy;

    // Second instance with NUM_IN=3 for the out-of-range select case.
    logic [3*W-1:0]   in_data3;
    logic [SW-1:0]    sel_a3, sel_b3;
    logic             in_valid3, in_ready3;
    logic [W-1:0]     op_a3, op_b3;
    logic             out_valid3, out_ready3, sel_err3;
    logic [1:0]       occupancy3;

    alu_operand_stage #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) u_dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_in_data   (in_data),
        .i_sel_a     (sel_a),
        .i_sel_b     (sel_b),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_op_a      (op_a),
        .o_op_b      (op_b),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_sel_err   (sel_err),
        .o_occupancy (occupancy)
    );

    alu_operand_stage #(.WIDTH(W), .NUM_IN(3), .SEL_W(SW)) u_dut3 (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_in_data   (in_data3),
        .i_sel_a     (sel_a3),
        .i_sel_b     (sel_b3),
        .i_in_valid  (in_valid3),
        .o_in_ready  (in_ready3),
        .o_op_a      (op_a3),
        .o_op_b      (op_b3),
        .o_out_valid (out_valid3),
        .i_out_ready (out_ready3),
        .o_sel_err   (sel_err3),
        .o_occupancy (occupancy3)
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    typedef struct {
        logic           v;
        logic [SW-1:0]  sa;
        logic [SW-1:0]  sb;
        logic [N*W-1:0] d;
        logic           ordy;
        logic [W-1:0]   ea;
        logic [W-1:0]   eb;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [N*W-1:0] mk(input logic [W-1:0] s0, input logic [W-1:0] s1,
                                          input logic [W-1:0] s2, input logic [W-1:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    // Compare DUT outputs against the scoreboard model; called at negedge.
    task automatic check_outputs(input string tag);
        int n;
        n = sb_q.size();
        chk({tag, " occupancy"}, W'(occupancy), W'(n));
        chk({tag, " in_ready"}, W'(in_ready), W'(n < 2));
        chk({tag, " out_valid"}, W'(out_valid), W'(n > 0));
        chk({tag, " sel_err"}, W'(sel_err), '0);
        if (n > 0) begin
            chk({tag, " op_a"}, op_a, sb_q[0].a);
            chk({tag, " op_b"}, op_b, sb_q[0].b);
        end
    endtask

    // One cycle: check, drive, update model, advance to the next negedge.
    task automatic step(input logic v, input logic [SW-1:0] sa, input logic [SW-1:0] sbs,
                        input logic [N*W-1:0] d, input logic ordy,
                        input logic [W-1:0] ea, input logic [W-1:0] eb, input string tag);
        bit acc, drn;
        exp_t e;
        check_outputs(tag);
        in_valid  = v;
        sel_a     = sa;
        sel_b     = sbs;
        in_data   = d;
        out_ready = ordy;
        acc = v && (sb_q.size() < 2);
        drn = (sb_q.size() > 0) && ordy;
        if (drn) void'(sb_q.pop_front());
        if (acc) begin
            e.a = ea;
            e.b = eb;
            sb_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        sb_q.delete();
        chk({tag, " rst out_valid"}, W'(out_valid), '0);
        chk({tag, " rst op_a"}, op_a, '0);
        chk({tag, " rst op_b"}, op_b, '0);
        chk({tag, " rst occupancy"}, W'(occupancy), '0);
        chk({tag, " rst sel_err"}, W'(sel_err), '0);
        reset = 1'b0;
        chk({tag, " rst in_ready"}, W'(in_ready), 32'd1);
    endtask

    vec_t tbl[8];

    initial begin
        logic [N*W-1:0] d;
        logic [W-1:0]   exp_a3;
        logic           exp_err3;

        tbl[0] = '{1'b1, 2'd2, 2'd3, mk(0, 0, 32'hAA, 32'h55), 1'b1, 32'hAA, 32'h55};
        tbl[1] = '{1'b0, 2'd0, 2'd0, mk(0, 0, 0, 0), 1'b1, 0, 0};
        tbl[2] = '{1'b1, 2'd0, 2'd1, mk(32'h11, 32'h22, 32'h33, 32'h44), 1'b0, 32'h11, 32'h22};
        tbl[3] = '{1'b1, 2'd3, 2'd3, mk(32'h11, 32'h22, 32'h33, 32'h44), 1'b0, 32'h44, 32'h44};
        tbl[4] = '{1'b1, 2'd1, 2'd2, mk(32'h91, 32'h92, 32'h93, 32'h94), 1'b1, 32'h92, 32'h93};
        tbl[5] = '{1'b0, 2'd0, 2'd0, mk(0, 0, 0, 0), 1'b1, 0, 0};
        tbl[6] = '{1'b0, 2'd0, 2'd0, mk(0, 0, 0, 0), 1'b1, 0, 0};
        tbl[7] = '{1'b0, 2'd0, 2'd0, mk(0, 0, 0, 0), 1'b1, 0, 0};

        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        sel_a      = '0;
        sel_b      = '0;
        in_data    = '0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b0;
        sel_a3     = '0;
        sel_b3     = '0;
        in_data3   = '0;
        @(negedge clk);
        do_reset("init");

        // Table vectors: single transfer, fill to two, held request, drain.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].v, tbl[i].sa, tbl[i].sb, tbl[i].d, tbl[i].ordy,
                 tbl[i].ea, tbl[i].eb, $sformatf("vec%0d", i));
        end

        // Back-pressure: 1, 2 accepted, 3 held until space frees.
        for (int k = 1; k <= 3; k++) begin
            d = mk(W'(k), W'(k + 100), 0, 0);
            step(1'b1, 2'd0, 2'd1, d, 1'b0, W'(k), W'(k + 100), $sformatf("bp%0d", k));
        end
        d = mk(32'd3, 32'd103, 0, 0);
        step(1'b1, 2'd0, 2'd1, d, 1'b1, 32'd3, 32'd103, "bp_drain1");
        step(1'b1, 2'd0, 2'd1, d, 1'b1, 32'd3, 32'd103, "bp_drain2");
        step(1'b0, 2'd0, 2'd1, d, 1'b1, 0, 0, "bp_drain3");
        step(1'b0, 2'd0, 2'd1, d, 1'b1, 0, 0, "bp_empty");

        // Full throughput: one pair per cycle, occupancy stays at one.
        for (int k = 0; k < 8; k++) begin
            d = mk(W'(10 + k), W'(200 + k), 0, 0);
            step(1'b1, 2'd0, 2'd1, d, 1'b1, W'(10 + k), W'(200 + k), $sformatf("tp%0d", k));
        end
        step(1'b0, 2'd0, 2'd0, d, 1'b1, 0, 0, "tp_tail");
        step(1'b0, 2'd0, 2'd0, d, 1'b1, 0, 0, "tp_empty");

        // Reset mid-operation with two entries held.
        step(1'b1, 2'd2, 2'd2, mk(0, 0, 32'h777, 0), 1'b0, 32'h777, 32'h777, "mr_fill1");
        step(1'b1, 2'd2, 2'd2, mk(0, 0, 32'h888, 0), 1'b0, 32'h888, 32'h888, "mr_fill2");
        check_outputs("mr_full");
        do_reset("mid");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'd0, 2'd0, '0, 1'b1, 0, 0, $sformatf("mr_after%0d", k));
        end

        // Same source on both operands; later source changes must not leak in.
        step(1'b1, 2'd1, 2'd1, mk(0, 32'hDEAD_BEEF, 0, 0), 1'b0,
             32'hDEAD_BEEF, 32'hDEAD_BEEF, "fw_acc");
        step(1'b0, 2'd1, 2'd1, mk(0, 32'h0BAD_F00D, 0, 0), 1'b0, 0, 0, "fw_stall1");
        step(1'b0, 2'd1, 2'd1, mk(0, 32'h1111_2222, 0, 0), 1'b0, 0, 0, "fw_stall2");
        step(1'b0, 2'd1, 2'd1, mk(0, 32'h1111_2222, 0, 0), 1'b1, 0, 0, "fw_drain");
        step(1'b0, 2'd1, 2'd1, mk(0, 32'h1111_2222, 0, 0), 1'b1, 0, 0, "fw_empty");

        // Out-of-range select on the NUM_IN=3 instance.
`ifdef ALU_OPERAND_SEL_CHECK_EN
        exp_a3   = 32'h0;
        exp_err3 = 1'b1;
`else
        exp_a3   = 32'h1234;
        exp_err3 = 1'b0;
`endif
        in_data3   = {32'h3, 32'h2, 32'h1234};
        sel_a3     = 2'd3;
        sel_b3     = 2'd0;
        in_valid3  = 1'b1;
        out_ready3 = 1'b0;
        @(negedge clk);
        in_valid3 = 1'b0;
        chk("oor out_valid", W'(out_valid3), 32'd1);
        chk("oor op_a", op_a3, exp_a3);
        chk("oor op_b", op_b3, 32'h1234);
        chk("oor sel_err", W'(sel_err3), W'(exp_err3));
        @(negedge clk);
        chk("oor sel_err held", W'(sel_err3), W'(exp_err3));
        out_ready3 = 1'b1;
        @(negedge clk);
        chk("oor drained valid", W'(out_valid3), '0);
        chk("oor drained sel_err", W'(sel_err3), '0);
        // In-range select on the same instance.
        sel_a3    = 2'd2;
        sel_b3    = 2'd1;
        in_valid3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0;
        chk("inr op_a", op_a3, 32'h3);
        chk("inr op_b", op_b3, 32'h2);
        chk("inr sel_err", W'(sel_err3), '0);
        chk("inr occupancy", W'(occupancy3), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
